wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Writeback scheduler for the dual-write-port architectural register file of the superscalar out-of-order core.
- Collects completed results from NREQ functional-unit requesters over valid/ready handshakes.
- Grants at most two per cycle using round-robin priority and never grants two writes to the same nonzero register in one cycle.
- Drives the register file write ports (we1/w_addr1/w_data1, we2/w_addr2/w_data2) from registered outputs.

Parameters:
NREQ, 4, number of requesters (2..8)
AW, 5, register address width
DW, 32, data width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
req_valid  input  NREQ  requester i holds a result
req_addr  input  NREQ*AW  destination of requester i, bits [i*AW +: AW]
req_data  input  NREQ*DW  result of requester i, bits [i*DW +: DW]
req_ready  output  NREQ  combinational grant; transfer when valid & ready
we1  output  1  RF port-1 write enable, registered
w_addr1  output  AW  RF port-1 address, registered
w_data1  output  DW  RF port-1 data, registered
we2  output  1  RF port-2 write enable, registered
w_addr2  output  AW  RF port-2 address, registered
w_data2  output  DW  RF port-2 data, registered
wb_count  output  2  number of grants made in the previous cycle (0..2), registered

Behaviour:
- Reset (rst=0, async):
  - Round-robin pointer ptr=0.
  - we1, we2, w_addr1, w_addr2, w_data1, w_data2 and wb_count all 0.
  - req_ready=0 while rst=0.
- Handshake:
  - A requester holds valid, addr and data stable until it sees ready.
  - Transfer occurs on a rising edge with valid & ready.
  - ready never asserts without valid.
- Selection each cycle (combinational), scanning i = ptr, ptr+1, ... mod NREQ:
  - A = first valid requester, sent to port 1.
  - B = next valid requester after A in scan order with addr_B != addr_A, or addr_A == 0. Sent to port 2.
  - Valid requesters that conflict with A are skipped and wait. The scan continues past them, so a later non-conflicting requester may win B.
  - req_ready[A] = 1; req_ready[B] = 1 if B exists. All others 0.
- Latency:
  - Granted results appear on the RF port outputs on the edge after the grant (1-cycle latency).
  - The RF commits them on the following edge.
- Port outputs on the grant edge:
  - w_addr/w_data capture the granted requester's values.
  - we = granted & (addr != 0). A request to r0 is consumed (ready=1) but produces no write.
  - No grant: we=0, addr/data hold their previous values.
- wb_count <= number of grants (0, 1 or 2), including r0 grants.
- Pointer update:
  - If any grant, ptr <= (index of last granted requester + 1) mod NREQ. That is B if present, else A.
  - No grant: ptr unchanged.
  - Guarantee: every persistently valid requester is granted within NREQ cycles.
- Same-address guarantee: the two ports never carry equal nonzero addresses in one cycle, so RF port-2-wins tie resolution never occurs.
- Program order of same-register writes across requesters is not tracked here. It is the issue/ROB logic's responsibility.
- Reset mid-operation:
  - Registered outputs clear immediately (async); a write in flight is dropped.
  - Requesters must re-present their results after reset.

Test Plan:
- Reset with all req_valid=1 and rst=0 -> req_ready=0, we1=we2=0, wb_count=0. Release rst -> first cycle grants req0 and req1 (distinct addrs), ptr becomes 2.
- req_valid=0010, addr1=7, data1=0xDEADBEEF -> req_ready=0010; next cycle we1=1, w_addr1=7, w_data1=0xDEADBEEF, we2=0, wb_count=1.
- req0 and req2 valid, both addr=9; req3 addr=4; ptr=0 -> grants 0 (port1) and 3 (port2); req2 waits. Next cycle ptr=0, only req2 valid -> req2 granted; RF sees addr 9 once per cycle.
- All 4 valid, distinct addrs, held 4 cycles -> grant pairs {0,1},{2,3},{0,1},{2,3}; each requester served every 2 cycles.
- req0 addr=0 and req1 addr=0 valid -> both ready=1; next cycle we1=we2=0, wb_count=2.
- Assert rst=0 between the grant edge and the write edge of a grant -> we1/we2 drop to 0 asynchronously, no RF write. After release, ptr=0.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Writeback scheduler for the dual-write-port architectural register file.
//   Each cycle it grants up to two of NREQ completed results in round-robin
//   order. It never grants two writes to the same nonzero register in one
//   cycle. The granted results are registered onto the two RF write ports.
//
// Ports
//   clk                  system clock, rising edge
//   rst                  asynchronous reset, active low
//   req_valid[NREQ]      requester i holds a result
//   req_addr[NREQ*AW]    destination register of requester i, bits [i*AW +: AW]
//   req_data[NREQ*DW]    result of requester i, bits [i*DW +: DW]
//   req_ready[NREQ]      combinational grant; transfer on valid & ready
//   we1/w_addr1/w_data1  RF write port 1 (registered)
//   we2/w_addr2/w_data2  RF write port 2 (registered)
//   wb_count[2]          grants made in the previous cycle (0..2)
module wb_port_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               we1,
  output logic [AW-1:0]      w_addr1,
  output logic [DW-1:0]      w_data1,
  output logic               we2,
  output logic [AW-1:0]      w_addr2,
  output logic [DW-1:0]      w_data2,
  output logic [1:0]         wb_count
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_next;
  logic [PW-1:0] last_idx;

  logic          a_found, b_found;
  logic [PW-1:0] a_idx, b_idx;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_data, b_data;

  // Round-robin scan starting at ptr. The first valid requester takes port 1.
  // The next valid requester that does not collide with port 1's register
  // takes port 2. Requesters that collide are skipped, and the scan goes on
  // past them. r0 never collides, because it produces no write.
  always_comb begin
    int unsigned   j;
    logic [PW-1:0] idx;
    logic [AW-1:0] cand_addr;
    j         = 0;
    idx       = '0;
    cand_addr = '0;
    a_found   = 1'b0;
    b_found   = 1'b0;
    a_idx     = '0;
    b_idx     = '0;
    a_addr    = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      idx       = PW'(j);
      cand_addr = req_addr[idx*AW +: AW];
      if (req_valid[idx]) begin
        if (!a_found) begin
          a_found = 1'b1;
          a_idx   = idx;
          a_addr  = cand_addr;
        end else if (!b_found && ((cand_addr != a_addr) || (a_addr == '0))) begin
          b_found = 1'b1;
          b_idx   = idx;
        end
      end
    end
  end

  assign a_data = req_data[a_idx*DW +: DW];
  assign b_addr = req_addr[b_idx*AW +: AW];
  assign b_data = req_data[b_idx*DW +: DW];

  // Requesters are held off while in reset.
  always_comb begin
    req_ready = '0;
    if (rst) begin
      if (a_found) req_ready[a_idx] = 1'b1;
      if (b_found) req_ready[b_idx] = 1'b1;
    end
  end

  // The pointer moves to the requester after the last one granted.
  always_comb begin
    last_idx = b_found ? b_idx : a_idx;
    if (int'(last_idx) == NREQ - 1) ptr_next = '0;
    else                            ptr_next = last_idx + PW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr      <= '0;
      we1      <= 1'b0;
      w_addr1  <= '0;
      w_data1  <= '0;
      we2      <= 1'b0;
      w_addr2  <= '0;
      w_data2  <= '0;
      wb_count <= '0;
    end else begin
      // A grant to r0 is consumed, but it leaves the write enable low.
      we1 <= a_found && (a_addr != '0);
      we2 <= b_found && (b_addr != '0);
      if (a_found) begin
        w_addr1 <= a_addr;
        w_data1 <= a_data;
        ptr     <= ptr_next;
      end
      if (b_found) begin
        w_addr2 <= b_addr;
        w_data2 <= b_data;
      end
      wb_count <= {1'b0, a_found} + {1'b0, b_found};
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [19:0]  req_addr;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         we1, we2;
  logic [4:0]   w_addr1, w_addr2;
  logic [31:0]  w_data1, w_data2;
  logic [1:0]   wb_count;

  wb_port_arbiter #(.NREQ(4), .AW(5), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .we1(we1), .w_addr1(w_addr1), .w_data1(w_data1),
    .we2(we2), .w_addr2(w_addr2), .w_data2(w_data2),
    .wb_count(wb_count)
  );

  typedef struct packed {
    logic        we1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        we2;
    logic [4:0]  a2;
    logic [31:0] d2;
    logic [1:0]  cnt;
  } wb_t;

  typedef struct {
    int         due;
    bit         is_wb;
    logic [3:0] rdy;
    wb_t        wb;
  } chk_t;

  chk_t q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  localparam logic [31:0] D0 = 32'h1111_0000, D1 = 32'h2222_0001;
  localparam logic [31:0] D2 = 32'h3333_0002, D3 = 32'h4444_0003;
  localparam logic [31:0] C0 = 32'hC0C0_0000, C2 = 32'hC2C2_0002;
  localparam logic [31:0] C3 = 32'hC3C3_0003, C4 = 32'hC4C4_0004;
  localparam logic [31:0] E0 = 32'hE000_0000, E1 = 32'hE111_0001;
  localparam logic [31:0] E2 = 32'hE222_0002, E3 = 32'hE333_0003;
  localparam logic [31:0] F0 = 32'hF000_0000, F1 = 32'hF111_0001;
  localparam logic [31:0] G0 = 32'h6060_6060;
  localparam logic [31:0] H0 = 32'h8080_0000, H2 = 32'h8282_0002;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic wb_t mk(input logic e1, input logic [4:0] a1, input logic [31:0] d1,
                             input logic e2, input logic [4:0] a2, input logic [31:0] d2,
                             input logic [1:0] c);
    wb_t r;
    r.we1 = e1; r.a1 = a1; r.d1 = d1;
    r.we2 = e2; r.a2 = a2; r.d2 = d2;
    r.cnt = c;
    return r;
  endfunction

  // wb_mode: 0 = no port check, 1 = ports checked after the next edge,
  // 2 = ports checked in this cycle (reset state).
  task automatic step(input logic r, input logic [3:0] v, input logic [19:0] a,
                      input logic [127:0] d, input logic [3:0] er,
                      input int wb_mode, input wb_t ew);
    chk_t c;
    @(posedge clk);
    #1;
    rst = r; req_valid = v; req_addr = a; req_data = d;
    c.due = cyc; c.is_wb = 1'b0; c.rdy = er; c.wb = '0;
    if (wb_mode == 2) begin
      c.is_wb = 1'b1; c.wb = ew; q.push_back(c);
      c.is_wb = 1'b0;
    end
    q.push_back(c);
    if (wb_mode == 1) begin
      c.due = cyc + 1; c.is_wb = 1'b1; c.wb = ew;
      q.push_back(c);
    end
  endtask

  // Monitor: runs at the falling edge, away from the active edge.
  chk_t me;
  wb_t  got;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      me = q.pop_front();
      total = total + 1;
      got = mk(we1, w_addr1, w_data1, we2, w_addr2, w_data2, wb_count);
      if (me.due != cyc) begin
        bad = bad + 1;
        $display("FAIL stale_check cyc=%0d due=%0d", cyc, me.due);
      end else if (me.is_wb) begin
        if (got !== me.wb) begin
          bad = bad + 1;
          $display("FAIL wb_ports cyc=%0d got we1=%b a1=%0d d1=%h we2=%b a2=%0d d2=%h cnt=%0d exp we1=%b a1=%0d d1=%h we2=%b a2=%0d d2=%h cnt=%0d",
                   cyc, got.we1, got.a1, got.d1, got.we2, got.a2, got.d2, got.cnt,
                   me.wb.we1, me.wb.a1, me.wb.d1, me.wb.we2, me.wb.a2, me.wb.d2, me.wb.cnt);
        end
      end else if (req_ready !== me.rdy) begin
        bad = bad + 1;
        $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, me.rdy);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    req_valid = 4'b1111;
    req_addr  = {5'd4, 5'd3, 5'd2, 5'd1};
    req_data  = {D3, D2, D1, D0};

    // Reset held with all requesters valid: no grants, ports cleared.
    step(1'b0, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, {D3, D2, D1, D0}, 4'b0000, 2, mk(0, 0, 0, 0, 0, 0, 0));
    step(1'b0, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, {D3, D2, D1, D0}, 4'b0000, 2, mk(0, 0, 0, 0, 0, 0, 0));
    // Release: req0 and req1 granted, ptr -> 2.
    step(1'b1, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, {D3, D2, D1, D0}, 4'b0011, 1, mk(1, 1, D0, 1, 2, D1, 2));
    // Single requester 1.
    step(1'b1, 4'b0010, {5'd0, 5'd0, 5'd7, 5'd0}, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0}, 4'b0010, 1,
         mk(1, 7, 32'hDEADBEEF, 0, 2, D1, 1));
    // req3 alone brings ptr back to 0.
    step(1'b1, 4'b1000, {5'd4, 5'd0, 5'd0, 5'd0}, {D3, 32'h0, 32'h0, 32'h0}, 4'b1000, 1, mk(1, 4, D3, 0, 2, D1, 1));
    // Same-register conflict: req2 skipped, req3 wins port 2, ptr -> 0.
    step(1'b1, 4'b1101, {5'd4, 5'd9, 5'd0, 5'd9}, {C3, C2, 32'h0, C0}, 4'b1001, 1, mk(1, 9, C0, 1, 4, C3, 2));
    step(1'b1, 4'b0100, {5'd0, 5'd9, 5'd0, 5'd0}, {32'h0, C2, 32'h0, 32'h0}, 4'b0100, 1, mk(1, 9, C2, 0, 4, C3, 1));
    // req3 alone again (ptr 3 -> 0), then an idle cycle: ports hold, no write.
    step(1'b1, 4'b1000, {5'd4, 5'd0, 5'd0, 5'd0}, {C4, 32'h0, 32'h0, 32'h0}, 4'b1000, 1, mk(1, 4, C4, 0, 4, C3, 1));
    step(1'b1, 4'b0000, 20'h0, 128'h0, 4'b0000, 1, mk(0, 4, C4, 0, 4, C3, 0));
    // All four valid, distinct addresses: pairs {0,1},{2,3},{0,1},{2,3}.
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 4'b1111, {5'd5, 5'd3, 5'd2, 5'd1}, {E3, E2, E1, E0}, 4'b0011, 1, mk(1, 1, E0, 1, 2, E1, 2));
      step(1'b1, 4'b1111, {5'd5, 5'd3, 5'd2, 5'd1}, {E3, E2, E1, E0}, 4'b1100, 1, mk(1, 3, E2, 1, 5, E3, 2));
    end
    // Two r0 requests: both consumed, no writes, count 2.
    step(1'b1, 4'b0011, {5'd0, 5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, F1, F0}, 4'b0011, 1, mk(0, 0, F0, 0, 0, F1, 2));
    // Grant req0, then reset between the grant edge and the write edge.
    step(1'b1, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd6}, {32'h0, 32'h0, 32'h0, G0}, 4'b0001, 0, mk(0, 0, 0, 0, 0, 0, 0));
    step(1'b0, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd6}, {32'h0, 32'h0, 32'h0, G0}, 4'b0000, 2, mk(0, 0, 0, 0, 0, 0, 0));
    // After release ptr=0: req0 beats the conflicting req2.
    step(1'b1, 4'b0101, {5'd0, 5'd8, 5'd0, 5'd8}, {32'h0, H2, 32'h0, H0}, 4'b0001, 1, mk(1, 8, H0, 0, 0, 0, 1));
    step(1'b1, 4'b0100, {5'd0, 5'd8, 5'd0, 5'd0}, {32'h0, H2, 32'h0, 32'h0}, 4'b0100, 1, mk(1, 8, H2, 0, 0, 0, 1));
    step(1'b1, 4'b0000, 20'h0, 128'h0, 4'b0000, 1, mk(0, 8, H2, 0, 0, 0, 0));

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      total = total + 1;
      bad = bad + 1;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
